mysystem_sysid_checker: RTL and testbench
=========================================

// Module: mysystem_sysid_checker
// PURPOSE
//  Avalon-MM master that reads the system ID slave (addr 0 = ID, addr 1 = timestamp) after reset
//  and on request, then compares both words against build-time expected values.
//  Sits between the sysid slave's control port and the board status logic (LEDs, boot gating).
//  Gives hardware a pass/fail flag so a stale FPGA image is detected before software runs.
// PARAMETERS
//  EXPECTED_ID     32'd0           expected word at address 0
//  EXPECTED_TS     32'd1591407027  expected word at address 1 (build timestamp)
//  TIMEOUT_CYCLES  255             max cycles a read may stall on avm_waitrequest (1..65535)
//  MAX_RETRIES     3               re-attempts of a timed-out read before giving up (0..15)
// PORTS
//  clock           in   1   system clock
//  reset_n         in   1   asynchronous active-low reset
//  start           in   1   1-cycle pulse: re-run the check; ignored while busy
//  avm_address     out  1   0 = ID word, 1 = timestamp word
//  avm_read        out  1   read strobe, held until accepted
//  avm_readdata    in   32  read data; valid in a cycle with avm_read=1 and avm_waitrequest=0
//  avm_waitrequest in   1   slave stall; tie 0 for a zero-wait slave
//  busy            out  1   check in progress
//  check_done      out  1   sticky: last check finished (pass, mismatch or timeout)
//  check_pass      out  1   sticky: both words matched
//  timeout_err     out  1   sticky: a read exhausted its retries
//  id_value        out  32  captured ID word
//  ts_value        out  32  captured timestamp word
// BEHAVIOUR
//  Reset (async, reset_n=0): state=BOOT; avm_read=0, avm_address=0, busy=0, check_done=0,
//   check_pass=0, timeout_err=0, id_value=0, ts_value=0, timeout counter=0, retry counter=0.
//  FSM: BOOT -> RD_ID -> RD_TS -> CMP -> DONE; IDLE/DONE -> RD_ID on start.
//   BOOT: one cycle after reset release, auto-starts (no start pulse needed).
//   Entering RD_ID: clear check_done/check_pass/timeout_err, busy=1, counters cleared.
//   RD_ID: avm_read=1, avm_address=0. Accept when avm_waitrequest=0: id_value<=avm_readdata,
//    go RD_TS next cycle. Read-to-capture latency = 1 cycle with no stall.
//   RD_TS: same with avm_address=1, capture into ts_value, go CMP.
//   CMP: check_pass <= (id_value==EXPECTED_ID)&&(ts_value==EXPECTED_TS); go DONE.
//   DONE: check_done=1, busy=0, avm_read=0; waits for start.
//  Full no-stall check: reset release to check_done=1 in 5 cycles.
//  Timeout: counter increments each stalled cycle of a read; on reaching TIMEOUT_CYCLES,
//   drop avm_read for 1 cycle, retry same address, retry count+1, counter cleared.
//   Retry count exceeding MAX_RETRIES -> timeout_err=1, check_pass=0, go DONE.
//  avm_address/avm_read stable while avm_waitrequest=1 (Avalon hold rule).
//  start while busy: ignored, no queueing. start coincident with DONE entry: ignored.
//  Reset mid-read: avm_read drops immediately (async); on release, full check re-runs from BOOT.
//  Sticky outputs change only on RD_ID entry, CMP, or timeout abort.
// CONFIGURATION
//  SYSID_CHECK_IRQ_EN defined: adds ports irq (out 1) and irq_ack (in 1). irq set on DONE entry
//   when check_pass=0; cleared by irq_ack=1 or RD_ID entry; irq_ack wins over set in same cycle.
//   Reset value 0.
//  SYSID_CHECK_IRQ_EN undefined: irq/irq_ack ports and logic absent; all else identical.
// TESTING
//  Zero-wait slave returning 0 / 1591407027 -> check_done=1, check_pass=1 on 5th cycle after
//   reset release; id_value=0, ts_value=32'd1591407027.
//  Slave returns ts=1591407028 -> check_done=1, check_pass=0, timeout_err=0.
//  waitrequest=1 for 10 cycles on each read -> pass, address/read held stable throughout.
//  waitrequest stuck 1, TIMEOUT_CYCLES=4, MAX_RETRIES=1 -> two 4-cycle attempts with 1-cycle
//   gap, then timeout_err=1, check_pass=0, check_done=1.
//  start pulsed mid-check and reset_n pulsed low mid-RD_TS -> start ignored; reset clears all
//   outputs, check re-runs and passes.
//  SYSID_CHECK_IRQ_EN: mismatch -> irq=1; irq_ack pulse -> irq=0 next cycle.

Source files
------------

// File: rtl/mysystem_sysid_checker.sv
// mysystem_sysid_checker
//   Avalon-MM read master that fetches the sysid ID word (address 0) and
//   build timestamp (address 1) after reset and on each start pulse. It then
//   compares both words against build-time constants and raises sticky
//   status flags for the board status logic.
//   Optional feature macro: SYSID_CHECK_IRQ_EN adds an irq/irq_ack pair that
//   flags a failed check (mismatch or timeout).
module mysystem_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1591407027,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
`ifdef SYSID_CHECK_IRQ_EN
    output logic        irq,
    input  logic        irq_ack,
`endif
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        check_done,
    output logic        check_pass,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        IDLE  = 3'd1,
        RD_ID = 3'd2,
        RD_TS = 3'd3,
        CMP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Last stalled cycle of an attempt, and the retry count at which we give up.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_t      state;
    state_t      next_state;
    logic [15:0] stall_cnt;
    logic [3:0]  retry_cnt;
    logic        gap;           // one idle cycle between a timed-out attempt and its retry

    logic        stalled;
    logic        accepted;
    logic        enter_rd_id;
    logic        capture_id;
    logic        capture_ts;
    logic        retry_start;
    logic        timeout_abort;
    logic        cmp_now;
    logic        words_match;

    // The read strobe and address decode straight from the state register, so
    // an asynchronous reset drops avm_read immediately. The address does not
    // change while the read is stalled because the state is held then.
    assign avm_read    = ((state == RD_ID) || (state == RD_TS)) && !gap;
    assign avm_address = (state == RD_TS);
    assign busy        = (state == RD_ID) || (state == RD_TS) || (state == CMP);

    assign stalled     = avm_read && avm_waitrequest;
    assign accepted    = avm_read && !avm_waitrequest;
    assign words_match = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-cycle control strobes.
    // NOTE: every signal gets a default before the case statement, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        next_state    = state;
        enter_rd_id   = 1'b0;
        capture_id    = 1'b0;
        capture_ts    = 1'b0;
        retry_start   = 1'b0;
        timeout_abort = 1'b0;
        cmp_now       = 1'b0;
        case (state)
            BOOT: begin
                next_state  = RD_ID;
                enter_rd_id = 1'b1;
            end
            IDLE, DONE: begin
                if (start) begin
                    next_state  = RD_ID;
                    enter_rd_id = 1'b1;
                end
            end
            RD_ID: begin
                if (accepted) begin
                    capture_id = 1'b1;
                    next_state = RD_TS;
                end else if (stalled && (stall_cnt == TIMEOUT_LAST)) begin
                    if (retry_cnt == RETRY_LIMIT) begin
                        timeout_abort = 1'b1;
                        next_state    = DONE;
                    end else begin
                        retry_start = 1'b1;
                    end
                end
            end
            RD_TS: begin
                if (accepted) begin
                    capture_ts = 1'b1;
                    next_state = CMP;
                end else if (stalled && (stall_cnt == TIMEOUT_LAST)) begin
                    if (retry_cnt == RETRY_LIMIT) begin
                        timeout_abort = 1'b1;
                        next_state    = DONE;
                    end else begin
                        retry_start = 1'b1;
                    end
                end
            end
            CMP: begin
                cmp_now    = 1'b1;
                next_state = DONE;
            end
            default: begin
                next_state = BOOT;
            end
        endcase
    end

    // Captured words, sticky status flags and the stall/retry counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            check_done  <= 1'b0;
            check_pass  <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
            stall_cnt   <= 16'd0;
            retry_cnt   <= 4'd0;
            gap         <= 1'b0;
        end else if (enter_rd_id) begin
            check_done  <= 1'b0;
            check_pass  <= 1'b0;
            timeout_err <= 1'b0;
            stall_cnt   <= 16'd0;
            retry_cnt   <= 4'd0;
            gap         <= 1'b0;
        end else begin
            gap <= retry_start;

            if (capture_id) begin
                id_value <= avm_readdata;
            end
            if (capture_ts) begin
                ts_value <= avm_readdata;
            end

            if (capture_id || capture_ts || retry_start || timeout_abort) begin
                stall_cnt <= 16'd0;
            end else if (stalled) begin
                stall_cnt <= stall_cnt + 16'd1;
            end

            // Retries are counted per read, so a successful read resets them.
            if (capture_id || capture_ts) begin
                retry_cnt <= 4'd0;
            end else if (retry_start) begin
                retry_cnt <= retry_cnt + 4'd1;
            end

            if (cmp_now) begin
                check_pass <= words_match;
                check_done <= 1'b1;
            end
            if (timeout_abort) begin
                timeout_err <= 1'b1;
                check_pass  <= 1'b0;
                check_done  <= 1'b1;
            end
        end
    end

`ifdef SYSID_CHECK_IRQ_EN
    // Failure interrupt: set on DONE entry without a pass, acknowledge has priority.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else if (irq_ack || enter_rd_id) begin
            irq <= 1'b0;
        end else if (timeout_abort || (cmp_now && !words_match)) begin
            irq <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mysystem_sysid_checker.sv
// tb_mysystem_sysid_checker
//   Directed bench: a default-parameter checker driven by a programmable-stall
//   slave model, plus a second checker (TIMEOUT_CYCLES=4, MAX_RETRIES=1)
//   whose slave holds waitrequest permanently high.
module tb_mysystem_sysid_checker;

    localparam logic [31:0] EXP_TS = 32'd1591407027;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        irq_ack;
    logic        avm_address, avm_read, avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy, check_done, check_pass, timeout_err;
    logic [31:0] id_value, ts_value;
    logic        irq;

    logic        reset_to_n;
    logic        to_address, to_read;
    logic        to_busy, to_done, to_pass, to_terr;
    logic [31:0] to_id, to_ts;
    logic        to_irq;

    logic [31:0] slave_id, slave_ts;
    int          stall_len;
    int          stall_cnt;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    // Slave model: each read is stalled for stall_len cycles, then accepted.
    assign avm_waitrequest = (stall_cnt < stall_len);
    assign avm_readdata    = avm_address ? slave_ts : slave_id;

    // Per-read stall counter of the slave model.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) stall_cnt <= 0;
        else if (avm_read && avm_waitrequest) stall_cnt <= stall_cnt + 1;
        else if (avm_read) stall_cnt <= 0;
    end

    mysystem_sysid_checker dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
`ifdef SYSID_CHECK_IRQ_EN
        .irq            (irq),
        .irq_ack        (irq_ack),
`endif
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .busy           (busy),
        .check_done     (check_done),
        .check_pass     (check_pass),
        .timeout_err    (timeout_err),
        .id_value       (id_value),
        .ts_value       (ts_value)
    );

    mysystem_sysid_checker #(.TIMEOUT_CYCLES(4), .MAX_RETRIES(1)) dut_to (
        .clock          (clock),
        .reset_n        (reset_to_n),
        .start          (1'b0),
`ifdef SYSID_CHECK_IRQ_EN
        .irq            (to_irq),
        .irq_ack        (1'b0),
`endif
        .avm_address    (to_address),
        .avm_read       (to_read),
        .avm_readdata   (32'd0),
        .avm_waitrequest(1'b1),
        .busy           (to_busy),
        .check_done     (to_done),
        .check_pass     (to_pass),
        .timeout_err    (to_terr),
        .id_value       (to_id),
        .ts_value       (to_ts)
    );

`ifndef SYSID_CHECK_IRQ_EN
    assign irq    = 1'b0;
    assign to_irq = 1'b0;
`endif

    // Advance one clock; returns at the falling edge where outputs are sampled.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (check_done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        if (check_done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_wait: check_done=%b after %0d cycles, want 1", tag, check_done, budget);
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({avm_read, avm_address, busy, check_done, check_pass, timeout_err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: read,addr,busy,done,pass,terr=%b want 000000",
                     {avm_read, avm_address, busy, check_done, check_pass, timeout_err});
        end
        vectors++;
        if (id_value !== 32'd0 || ts_value !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_words: id=%h ts=%h want 0/0", id_value, ts_value);
        end
    endtask

    // Release reset and follow the zero-wait check cycle by cycle.
    task automatic test_pass_after_reset();
        reset_n = 1'b1;                               // BOOT cycle
        tick();                                       // RD_ID
        vectors++;
        if (avm_read !== 1'b1 || avm_address !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL boot_rd_id: read=%b addr=%b busy=%b want 1/0/1", avm_read, avm_address, busy);
        end
        tick();                                       // RD_TS
        vectors++;
        if (avm_read !== 1'b1 || avm_address !== 1'b1) begin
            miscompares++;
            $display("FAIL boot_rd_ts: read=%b addr=%b want 1/1", avm_read, avm_address);
        end
        tick();                                       // CMP
        vectors++;
        if (check_done !== 1'b0 || avm_read !== 1'b0 || ts_value !== EXP_TS) begin
            miscompares++;
            $display("FAIL boot_cmp: done=%b read=%b ts=%0d want 0/0/%0d", check_done, avm_read, ts_value, EXP_TS);
        end
        tick();                                       // DONE, 5th cycle after release
        vectors++;
        if (check_done !== 1'b1 || check_pass !== 1'b1 || timeout_err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL boot_done: done=%b pass=%b terr=%b busy=%b want 1/1/0/0",
                     check_done, check_pass, timeout_err, busy);
        end
        vectors++;
        if (id_value !== 32'd0 || ts_value !== EXP_TS) begin
            miscompares++;
            $display("FAIL boot_words: id=%0d ts=%0d want 0/%0d", id_value, ts_value, EXP_TS);
        end
    endtask

    task automatic test_ts_mismatch();
        slave_ts = 32'd1591407028;
        pulse_start();
        vectors++;
        if (busy !== 1'b1 || check_done !== 1'b0 || check_pass !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_clear: busy=%b done=%b pass=%b want 1/0/0", busy, check_done, check_pass);
        end
        wait_done(20, "ts_mismatch");
        vectors++;
        if (check_pass !== 1'b0 || timeout_err !== 1'b0 || ts_value !== 32'd1591407028) begin
            miscompares++;
            $display("FAIL ts_mismatch: pass=%b terr=%b ts=%0d want 0/0/1591407028", check_pass, timeout_err, ts_value);
        end
        slave_ts = EXP_TS;
    endtask

    task automatic test_id_mismatch();
        slave_id = 32'hDEAD_BEEF;
        pulse_start();
        wait_done(20, "id_mismatch");
        vectors++;
        if (check_pass !== 1'b0 || id_value !== 32'hDEAD_BEEF || ts_value !== EXP_TS) begin
            miscompares++;
            $display("FAIL id_mismatch: pass=%b id=%h ts=%0d want 0/deadbeef/%0d", check_pass, id_value, ts_value, EXP_TS);
        end
        slave_id = 32'd0;
    endtask

    // Ten stall cycles on each read; the request must stay put while stalled.
    task automatic test_stall();
        int   stalls_id = 0;
        int   stalls_ts = 0;
        logic prev_stall;
        logic prev_addr;
        stall_len = 10;
        pulse_start();
        prev_stall = 1'b0;
        prev_addr  = 1'b0;
        for (int i = 0; i < 60 && check_done !== 1'b1; i++) begin
            if (prev_stall) begin
                vectors++;
                if (avm_read !== 1'b1 || avm_address !== prev_addr) begin
                    miscompares++;
                    $display("FAIL stall_hold: read=%b addr=%b want 1/%b", avm_read, avm_address, prev_addr);
                end
            end
            if (avm_read && avm_waitrequest) begin
                if (avm_address) stalls_ts++;
                else stalls_id++;
            end
            prev_stall = avm_read && avm_waitrequest;
            prev_addr  = avm_address;
            tick();
        end
        vectors++;
        if (stalls_id != 10 || stalls_ts != 10) begin
            miscompares++;
            $display("FAIL stall_count: id_stalls=%0d ts_stalls=%0d want 10/10", stalls_id, stalls_ts);
        end
        vectors++;
        if (check_done !== 1'b1 || check_pass !== 1'b1 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_pass: done=%b pass=%b terr=%b want 1/1/0", check_done, check_pass, timeout_err);
        end
        stall_len = 0;
    endtask

    // start is held through RD_ID, RD_TS and CMP (including the edge into DONE).
    task automatic test_start_ignored();
        start = 1'b1;
        tick();                                       // accepted: RD_ID
        tick();                                       // RD_TS
        tick();                                       // CMP
        tick();                                       // DONE, start coincident with entry
        start = 1'b0;
        vectors++;
        if (check_done !== 1'b1 || check_pass !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_busy: done=%b pass=%b busy=%b want 1/1/0", check_done, check_pass, busy);
        end
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || check_done !== 1'b1 || avm_read !== 1'b0) begin
            miscompares++;
            $display("FAIL start_queued: busy=%b done=%b read=%b want 0/1/0", busy, check_done, avm_read);
        end
    endtask

    task automatic test_reset_mid_read();
        stall_len = 3;
        pulse_start();                                // RD_ID
        start = 1'b1;                                 // ignored while busy
        for (int i = 0; i < 20 && avm_address !== 1'b1; i++) tick();
        start = 1'b0;
        vectors++;
        if (avm_read !== 1'b1 || avm_address !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_rd_ts: read=%b addr=%b want 1/1", avm_read, avm_address);
        end
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if (avm_read !== 1'b0 || busy !== 1'b0 || ts_value !== 32'd0 || id_value !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_reset: read=%b busy=%b id=%h ts=%h want 0/0/0/0", avm_read, busy, id_value, ts_value);
        end
        stall_len = 0;
        @(negedge clock);
        test_reset();
        test_pass_after_reset();
    endtask

    // Stuck waitrequest on dut_to: 4 read cycles, 1 gap, 4 read cycles, abort.
    task automatic test_timeout();
        logic [10:0] exp_read;
        exp_read   = 11'b01111011110;                 // bit s = read expected at sample s
        reset_to_n = 1'b1;
        for (int s = 0; s <= 10; s++) begin
            vectors++;
            if (to_read !== exp_read[s] || to_address !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_seq[%0d]: read=%b addr=%b want %b/0", s, to_read, to_address, exp_read[s]);
            end
            if (s < 10) tick();
        end
        vectors++;
        if (to_done !== 1'b1 || to_terr !== 1'b1 || to_pass !== 1'b0 || to_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_flags: done=%b terr=%b pass=%b busy=%b want 1/1/0/0", to_done, to_terr, to_pass, to_busy);
        end
    endtask

    task automatic test_irq();
`ifdef SYSID_CHECK_IRQ_EN
        slave_ts = 32'd1;
        pulse_start();
        wait_done(20, "irq");
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_set: irq=%b want 1", irq);
        end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_ack: irq=%b want 0", irq);
        end
        vectors++;
        if (to_irq !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_timeout: irq=%b want 1", to_irq);
        end
        slave_ts = EXP_TS;
`endif
    endtask

    initial begin
        reset_n    = 1'b0;
        reset_to_n = 1'b0;
        start      = 1'b0;
        irq_ack    = 1'b0;
        slave_id   = 32'd0;
        slave_ts   = EXP_TS;
        stall_len  = 0;
        repeat (3) @(negedge clock);
        test_reset();
        test_pass_after_reset();
        test_ts_mismatch();
        test_stall();
        test_start_ignored();
        test_id_mismatch();
        test_reset_mid_read();
        test_timeout();
        test_irq();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
